// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer shared definitions: scoreboard slot record, register
// address width and the EXE operand forwarding select encodings.
package hazard_sequencer_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_e;

  // One in-flight instruction as seen by the sequencer.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  two_src;
    logic                  wb_en;
    logic                  mem_read;
    logic                  status_en;
  } slot_t;

  // True when the slot holds a live instruction that will write register r.
  function automatic logic slot_writes(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: ID-stage control inputs, branch/memory status and the
// sequencing/forwarding outputs. master = pipeline side, slave = sequencer.
interface hazard_sequencer_if
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) ();

  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_src1;
  logic [REG_ADDR_W-1:0]  id_src2;
  logic                   id_two_src;
  logic [REG_ADDR_W-1:0]  id_dest;
  logic                   id_wb_en;
  logic                   id_mem_read;
  logic                   id_status_en;
  logic                   id_cond_uses_flags;
  logic                   exe_branch_taken;
  logic                   mem_ready;

  logic                   stall;
  logic                   bubble;
  logic                   flush;
  logic                   freeze;
  logic [1:0]             fwd_sel_a;
  logic [1:0]             fwd_sel_b;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest,
           id_wb_en, id_mem_read, id_status_en, id_cond_uses_flags,
           exe_branch_taken, mem_ready,
    input  stall, bubble, flush, freeze, fwd_sel_a, fwd_sel_b, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest,
           id_wb_en, id_mem_read, id_status_en, id_cond_uses_flags,
           exe_branch_taken, mem_ready,
    output stall, bubble, flush, freeze, fwd_sel_a, fwd_sel_b, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_slot.sv
// hazard_scoreboard_slot: one stage of the shadow scoreboard. hold_i keeps
// the current entry, bubble_i loads an empty (invalid) entry.
module hazard_scoreboard_slot
  import hazard_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  // Next entry: hold, bubble or capture the upstream stage.
  always_comb begin
    slot_d = slot_q;
    if (!hold_i) begin
      if (bubble_i) slot_d = '0;
      else          slot_d = d_i;
    end
  end

  // Slot register, cleared to an invalid entry on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign q_o = slot_q;

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/bubble/flush/freeze control and EXE forwarding
// selects for the five-stage core, driven from a shadow scoreboard of the
// EX, MEM and WB instructions.
// Build option: define FORWARDING_EN to enable operand forwarding; the RAW
// stall is then limited to load-use. Without it fwd_sel_a/b are 00.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_sequencer_if.slave bus
);

  slot_t id_slot;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;

  logic freeze;
  logic flush;
  logic stall;
  logic raw_hz;
  logic flag_hz;
  logic ex_bubble;

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  // Pack the ID instruction into a scoreboard record.
  always_comb begin
    id_slot           = '0;
    id_slot.valid     = bus.id_valid;
    id_slot.dest      = bus.id_dest;
    id_slot.src1      = bus.id_src1;
    id_slot.src2      = bus.id_src2;
    id_slot.two_src   = bus.id_two_src;
    id_slot.wb_en     = bus.id_wb_en;
    id_slot.mem_read  = bus.id_mem_read;
    id_slot.status_en = bus.id_status_en;
  end

  // Hazard detection with precedence freeze > flush > stall.
  always_comb begin
    freeze = ~bus.mem_ready;
    flush  = bus.exe_branch_taken & ~freeze;
`ifdef FORWARDING_EN
    raw_hz = ex_q.mem_read &
             (slot_writes(ex_q, bus.id_src1) |
              (bus.id_two_src & slot_writes(ex_q, bus.id_src2)));
`else
    raw_hz = slot_writes(ex_q, bus.id_src1) | slot_writes(mem_q, bus.id_src1) |
             (bus.id_two_src & (slot_writes(ex_q, bus.id_src2) |
                                slot_writes(mem_q, bus.id_src2)));
`endif
    flag_hz   = bus.id_valid & bus.id_cond_uses_flags & ex_q.valid & ex_q.status_en;
    stall     = bus.id_valid & (raw_hz | flag_hz) & ~flush & ~freeze;
    ex_bubble = ~bus.id_valid | stall | flush;
  end

  hazard_scoreboard_slot u_slot_ex (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (ex_bubble),
    .d_i      (id_slot),
    .q_o      (ex_q)
  );

  hazard_scoreboard_slot u_slot_mem (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hazard_scoreboard_slot u_slot_wb (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

`ifdef FORWARDING_EN
  // MEM wins over WB; a load in MEM has no data yet so it never forwards.
  function automatic fwd_sel_e fwd_pick(slot_t m, slot_t w, logic [REG_ADDR_W-1:0] src);
    if (slot_writes(m, src) && !m.mem_read) return FWD_MEM;
    if (slot_writes(w, src))                return FWD_WB;
    return FWD_REGFILE;
  endfunction
`endif

  // Operand selects for the instruction currently in EX.
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
`ifdef FORWARDING_EN
    fwd_a = fwd_pick(mem_q, wb_q, ex_q.src1);
    if (ex_q.two_src) fwd_b = fwd_pick(mem_q, wb_q, ex_q.src2);
`endif
  end

  // Saturating count of stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  // Slot fields a given build does not read are collected here so they are
  // visibly consumed rather than left dangling.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

  assign bus.stall       = stall;
  assign bus.bubble      = stall;
  assign bus.flush       = flush;
  assign bus.freeze      = freeze;
  assign bus.fwd_sel_a   = fwd_a;
  assign bus.fwd_sel_b   = fwd_b;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencing controller for the five-stage ARM core. Sits beside the ID stage and tracks, in its own shadow scoreboard, the destination/control bits of the instructions in EXE, MEM and WB. From this it decides every cycle whether the pipeline must:

- stall for a RAW or flag hazard,
- flush on a taken branch,
- freeze on a memory wait.

It also drives the EXE operand forwarding selects.

## Interface

- REG_ADDR_W, 4, register address width (r0–r15)
- STALL_CNT_W, 16, width of the stall statistics counter

Ports:

- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1 / id_src2  in  REG_ADDR_W  ID source registers (Rn, Rm/Rd-for-STR)
- id_two_src  in  1  id_src2 is read (register operand or STR)
- id_dest  in  REG_ADDR_W  ID destination register
- id_wb_en, id_mem_read, id_status_en  in  1  control-unit outputs for the ID instruction
- id_cond_uses_flags  in  1  ID condition field is not AL
- exe_branch_taken  in  1  branch in EXE resolved taken this cycle
- mem_ready  in  1  data memory completes this cycle; 0 = wait
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- freeze  out  1  hold every pipeline register
- fwd_sel_a / fwd_sel_b  out  2  EXE operand select: 00 regfile, 01 MEM result, 10 WB value
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation

**Scoreboard slots.** There are three slots: EX, MEM, WB. Each holds {valid, dest, src1, src2, two_src, wb_en, mem_read, status_en}.

**Slot advance.** On each cycle with freeze=0, the slots shift:

- WB ← MEM
- MEM ← EX
- EX ← ID fields, but only if id_valid and neither stall nor flush; otherwise EX ← bubble (valid=0).

**Freeze.** freeze = ~mem_ready. While frozen:

- All slots hold.
- stall, bubble and flush are forced to 0.

**Flush.** flush = exe_branch_taken & ~freeze. The ID instruction is discarded and EX is loaded with a bubble.

**RAW hazard.** A source matches a slot when valid & wb_en & dest==src. src2 is only checked when id_two_src=1.

- Without forwarding: hazard if either ID source matches EX or MEM. WB needs no check because the register file is write-first.
- With forwarding: hazard only on load-use, i.e. EX.mem_read & a match on EX.

**Flag hazard.** id_valid & id_cond_uses_flags & EX.valid & EX.status_en.

**stall / bubble.** stall = bubble = id_valid & (RAW | flag hazard) & ~flush & ~freeze.

**Precedence.** rst > freeze > flush > stall.

**Forwarding selects.** These are computed for the instruction currently in EX:

- 01 if MEM.valid & MEM.wb_en & ~MEM.mem_read & MEM.dest==EX.src.
- Otherwise 10 if WB.valid & WB.wb_en & WB.dest==EX.src.
- Otherwise 00.
- MEM wins over WB. fwd_sel_b only matches when EX.two_src.

**stall_count.** Increments on each cycle with stall=1 and saturates at all-ones.

## Timing

- stall, bubble, flush, freeze and fwd_sel are combinational from slot state and current inputs. They are valid within the same cycle and have zero latency.
- Scoreboard and counter update on the rising clk edge.
- Load-use costs exactly 1 stall cycle; the next cycle the load sits in MEM and is forwarded from WB afterwards. Without forwarding, a dependent instruction stalls 2 cycles behind an ALU producer.
- A branch-taken flush and a concurrent hazard: flush asserts, stall=0.
- A freeze that coincides with exe_branch_taken: the flush is deferred. Freeze holds the branch in EXE, so flush asserts in the first cycle with mem_ready=1.
- Reset (async, any time, including mid-stall or mid-freeze):
  - All slots go to valid=0 and stall_count=0.
  - Outputs then evaluate to stall=bubble=flush=0, fwd_sel=00, and freeze=~mem_ready.

## Configuration

- FORWARDING_EN defined:
  - Forwarding logic is present.
  - The RAW check is reduced to load-use only.
- FORWARDING_EN undefined:
  - fwd_sel_a and fwd_sel_b are tied to 00.
  - The full EX/MEM RAW stall check applies.
  - The src fields in the slots may be optimized away.

Ports are identical in both builds.

## Structure

- Shared package holds:
  - the slot record typedef
  - REG_ADDR_W default
  - the forwarding select encodings FWD_REGFILE=00, FWD_MEM=01, FWD_WB=10
- One natural sub-module: hazard_scoreboard_slot, the per-stage register with hold/bubble controls, instantiated three times.

## Test plan

- **ALU RAW, no forwarding.** ADD r1 then SUB r2,r1 → stall=bubble=1 for 2 cycles, SUB enters EX on the 3rd cycle; stall_count=2.
- **ALU RAW, FORWARDING_EN.** Same sequence → no stall; fwd_sel_a=01 when SUB is in EX.
- **Load-use, FORWARDING_EN.** LDR r3 then ADD r4,r3,r3 → exactly 1 stall cycle, then fwd_sel_a=fwd_sel_b=10.
- **Flag hazard.** CMP (status_en) then conditional MOVEQ → 1 stall cycle.
- **Branch flush.** exe_branch_taken=1 while ID holds a dependent instruction → flush=1, stall=0, EX.valid=0 next cycle.
- **Freeze, then reset.** mem_ready=0 for 3 cycles during a pending stall → freeze=1, slots and stall_count held. Assert rst mid-freeze → all slots invalid, stall_count=0.
